traffic_phase_sequencer: RTL and testbench
==========================================

# traffic_phase_sequencer

Registered phase sequencer that drives the 2-bit phase code consumed by the light-pattern decoder. Holds the current intersection phase and the long and short dwell counters. Advances main-green → main-yellow → side-green → side-yellow → main-green. Main green is held until a side-road request is pending, so the decoder's outputs change only on clock edges.

## Interface
- LONG_CYCLES, 8: dwell of each green phase in clock cycles (minimum dwell for main green); ≥1.
- SHORT_CYCLES, 3: dwell of each yellow phase in clock cycles; ≥1.
- CW, derived: counter width, $clog2(max(LONG_CYCLES,SHORT_CYCLES)+1).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active low.
- side_request  in  1  side-road vehicle sensor, level, synchronous to clk.
- phase  out  2  current phase code; feeds the decoder's state input.
- phase_entry  out  1  high for the first cycle of every phase, including the first cycle after reset release.
- dwell_count  out  CW  remaining cycles in the current phase minus one.
- req_pending  out  1  latched side request not yet served.

## Operation
- Phase encoding (Gray): 2'b00 main green, 2'b01 main yellow, 2'b11 side green, 2'b10 side yellow. No other code reachable.
- Counter:
  - On entry to a phase, dwell_count loads its dwell minus 1: LONG_CYCLES-1 for greens, SHORT_CYCLES-1 for yellows.
  - It decrements by 1 per cycle while nonzero and saturates at 0.
- Transitions occur on the edge where dwell_count==0, with these conditions:
  - 00→01 only if req_latched | side_request; otherwise hold 00 with count at 0.
  - 01→11 unconditional.
  - 11→10 unconditional.
  - 10→00 unconditional.
- Request latch:
  - req_latched sets on any edge where side_request=1.
  - It clears on the edge that enters 11 (clear wins over a simultaneous set).
  - Requests arriving during 11 or 10 re-set the latch and are served in the next cycle round.
  - req_pending = req_latched.
- phase_entry is a registered flag: set on any transition edge, cleared otherwise.
- Main green therefore lasts max(LONG_CYCLES, cycles until request) cycles. Every other phase lasts exactly its dwell.

## Timing
- Reset values while rst_n=0:
  - phase=2'b00
  - dwell_count=LONG_CYCLES-1
  - req_pending=0
  - phase_entry=1
- Reset is asynchronous: outputs take reset values immediately on rst_n fall, from any phase and any counter value.
- First clock edge after rst_n rises: phase_entry→0, dwell_count decrements. Main green dwell is counted from the first post-reset cycle.
- A phase entered at edge t holds phase for exactly N edges (N = its dwell). The transition occurs at edge t+N.
- Request latency when main green has expired (count==0):
  - side_request high before edge k → phase=01 after edge k.
  - This is a one-edge response; side_request is used directly, not only the latch.
- Request before expiry: it is latched, and the transition occurs at the edge where count reaches its expiry, i.e. exactly LONG_CYCLES edges after entry.
- A side_request pulse of one cycle is never lost.
- No combinational path from side_request to phase. All outputs are registered except req_pending, which is the latch register itself.

## Test plan
- Reset, no request (LONG=8, SHORT=3): phase stays 00 indefinitely. dwell_count reads 7,6,…,0, then holds 0. phase_entry is high only in cycle 0.
- Request held high from reset: phase sequence 00×8, 01×3, 11×8, 10×3, 00…. phase_entry pulses at each change. req_pending clears on entry to 11, then re-sets next edge since the request is still high.
- Late request: idle 20 cycles in 00, then a single-cycle side_request pulse before edge k. Required: phase=01 after edge k, dwell_count=2, req_pending goes 1 then 0 after entry to 11.
- Early short pulse: 1-cycle side_request at cycle 2 of main green. Required: req_pending=1 from edge 3, phase goes 00→01 at edge 8 exactly.
- Request during side green: pulse in phase 11. Required: after 10→00, main green lasts exactly 8 cycles, then 01 follows without further stimulus.
- Reset mid-phase: assert rst_n=0 in phase 11 with dwell_count=4. Required: phase=00, dwell_count=7, req_pending=0, phase_entry=1 before the next clk edge. Normal sequencing resumes after release.

Source files
------------

// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer
//
// Registered intersection phase sequencer. It holds the current phase, a dwell
// counter and a latched side-road request, and cycles:
// main green -> main yellow -> side green -> side yellow -> main green.
// Main green is held past its minimum dwell until a side request is seen.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   side_request  side-road vehicle sensor (level, synchronous to clk)
//   phase         Gray-coded phase: 00 main green, 01 main yellow,
//                 11 side green, 10 side yellow
//   phase_entry   high for the first cycle of every phase (and out of reset)
//   dwell_count   remaining cycles in the current phase minus one
//   req_pending   latched side request not yet served

module traffic_phase_sequencer #(
    parameter int unsigned LONG_CYCLES  = 8,
    parameter int unsigned SHORT_CYCLES = 3,
    localparam int unsigned MAX_CYCLES  =
        (LONG_CYCLES > SHORT_CYCLES) ? LONG_CYCLES : SHORT_CYCLES,
    localparam int unsigned CW          = $clog2(MAX_CYCLES + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          side_request,
    output logic [1:0]    phase,
    output logic          phase_entry,
    output logic [CW-1:0] dwell_count,
    output logic          req_pending
);

    typedef enum logic [1:0] {
        MainGreen  = 2'b00,
        MainYellow = 2'b01,
        SideGreen  = 2'b11,
        SideYellow = 2'b10
    } phase_e;

    localparam logic [CW-1:0] LongLoad  = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] ShortLoad = CW'(SHORT_CYCLES - 1);

    phase_e        phase_q, phase_d;
    logic [CW-1:0] count_q, count_d;
    logic          entry_q, entry_d;
    logic          req_q, req_d;

    logic expired;
    logic advance;

    always_comb begin
        expired = (count_q == '0);
        phase_d = phase_q;

        case (phase_q)
            // side_request is used directly so an expired main green answers in one edge.
            MainGreen:  if (expired && (req_q || side_request)) phase_d = MainYellow;
            MainYellow: if (expired) phase_d = SideGreen;
            SideGreen:  if (expired) phase_d = SideYellow;
            SideYellow: if (expired) phase_d = MainGreen;
            default:    phase_d = MainGreen;
        endcase

        advance = (phase_d != phase_q);

        if (advance) begin
            count_d = (phase_d == MainGreen || phase_d == SideGreen) ? LongLoad : ShortLoad;
        end else if (expired) begin
            count_d = count_q;
        end else begin
            count_d = count_q - CW'(1);
        end

        // Entering side green serves the request; this clear beats a same-edge set.
        if (advance && phase_d == SideGreen) begin
            req_d = 1'b0;
        end else begin
            req_d = req_q | side_request;
        end

        entry_d = advance;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= MainGreen;
            count_q <= LongLoad;
            entry_q <= 1'b1;
            req_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            count_q <= count_d;
            entry_q <= entry_d;
            req_q   <= req_d;
        end
    end

    assign phase       = phase_q;
    assign phase_entry = entry_q;
    assign dwell_count = count_q;
    assign req_pending = req_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed testbench for traffic_phase_sequencer (LONG_CYCLES=8, SHORT_CYCLES=3).
// Inputs change and outputs are sampled on the falling clock edge; "cycle c"
// means the state visible after the c-th rising edge following reset release.

module tb_traffic_phase_sequencer;

    logic       clk;
    logic       rst_n;
    logic       side_request;
    logic [1:0] phase;
    logic       phase_entry;
    logic [3:0] dwell_count;
    logic       req_pending;

    int total;
    int bad;

    traffic_phase_sequencer #(
        .LONG_CYCLES (8),
        .SHORT_CYCLES(3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .side_request(side_request),
        .phase       (phase),
        .phase_entry (phase_entry),
        .dwell_count (dwell_count),
        .req_pending (req_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] ph, input int cnt,
                           input logic ent, input logic req);
        chk({tag, ".phase"}, 32'(phase), 32'(ph));
        chk({tag, ".count"}, 32'(dwell_count), 32'(cnt));
        chk({tag, ".entry"}, 32'(phase_entry), 32'(ent));
        chk({tag, ".req"}, 32'(req_pending), 32'(req));
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench at cycle 0 (reset just released on a falling edge).
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [1:0] exp_ph;
    int         exp_cnt;
    logic       exp_ent;
    logic       exp_req;

    initial begin
        total        = 0;
        bad          = 0;
        rst_n        = 1'b0;
        side_request = 1'b0;

        // Reset values while held in reset.
        tick(2);
        chk_all("in_reset", 2'b00, 7, 1'b1, 1'b0);

        // ---- Reset, no request: count 7..0 then holds, phase stays 00.
        do_reset();
        chk_all("idle_c0", 2'b00, 7, 1'b1, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            tick(1);
            chk_all($sformatf("idle_c%0d", c), 2'b00, (c < 7) ? 7 - c : 0, 1'b0, 1'b0);
        end

        // ---- Request held high from reset: 00x8, 01x3, 11x8, 10x3, 00...
        side_request = 1'b1;
        do_reset();
        for (int c = 0; c <= 24; c++) begin
            if (c > 0) tick(1);
            if (c < 8) begin
                exp_ph = 2'b00; exp_cnt = 7 - c;
            end else if (c < 11) begin
                exp_ph = 2'b01; exp_cnt = 2 - (c - 8);
            end else if (c < 19) begin
                exp_ph = 2'b11; exp_cnt = 7 - (c - 11);
            end else if (c < 22) begin
                exp_ph = 2'b10; exp_cnt = 2 - (c - 19);
            end else begin
                exp_ph = 2'b00; exp_cnt = 7 - (c - 22);
            end
            exp_ent = (c == 0 || c == 8 || c == 11 || c == 19 || c == 22);
            exp_req = (c != 0 && c != 11);
            chk_all($sformatf("held_c%0d", c), exp_ph, exp_cnt, exp_ent, exp_req);
        end
        side_request = 1'b0;

        // ---- Late request: one-edge response once main green has expired.
        do_reset();
        tick(20);
        chk_all("late_c20", 2'b00, 0, 1'b0, 1'b0);
        side_request = 1'b1;
        tick(1);
        side_request = 1'b0;
        chk_all("late_c21", 2'b01, 2, 1'b1, 1'b1);
        tick(1);
        chk_all("late_c22", 2'b01, 1, 1'b0, 1'b1);
        tick(2);
        chk_all("late_c24", 2'b11, 7, 1'b1, 1'b0);

        // ---- Early one-cycle pulse during cycle 2 of main green.
        do_reset();
        tick(2);
        side_request = 1'b1;
        tick(1);
        side_request = 1'b0;
        chk_all("early_c3", 2'b00, 4, 1'b0, 1'b1);
        tick(4);
        chk_all("early_c7", 2'b00, 0, 1'b0, 1'b1);
        tick(1);
        chk_all("early_c8", 2'b01, 2, 1'b1, 1'b1);
        tick(3);
        chk_all("early_c11", 2'b11, 7, 1'b1, 1'b0);

        // ---- Pulse during side green is served in the next round.
        side_request = 1'b1;
        tick(1);
        side_request = 1'b0;
        chk_all("side_c12", 2'b11, 6, 1'b0, 1'b1);
        tick(7);
        chk_all("side_c19", 2'b10, 2, 1'b1, 1'b1);
        tick(3);
        chk_all("side_c22", 2'b00, 7, 1'b1, 1'b1);
        tick(7);
        chk_all("side_c29", 2'b00, 0, 1'b0, 1'b1);
        tick(1);
        chk_all("side_c30", 2'b01, 2, 1'b1, 1'b1);
        tick(3);
        chk_all("side_c33", 2'b11, 7, 1'b1, 1'b0);

        // ---- Asynchronous reset in side green with count 4 and a pending request.
        side_request = 1'b1;
        tick(1);
        side_request = 1'b0;
        tick(2);
        chk_all("mid_c36", 2'b11, 4, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("mid_async", 2'b00, 7, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        chk_all("resume_c0", 2'b00, 7, 1'b1, 1'b0);
        tick(1);
        chk_all("resume_c1", 2'b00, 6, 1'b0, 1'b0);
        tick(6);
        chk_all("resume_c7", 2'b00, 0, 1'b0, 1'b0);
        side_request = 1'b1;
        tick(1);
        side_request = 1'b0;
        chk_all("resume_c8", 2'b01, 2, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
